// File: rtl/alu_control_unit.sv
// Decode-stage ALU controller. It maps the main-control operation class and
// the R-type function field to a 3-bit ALU select. It also flags undefined
// encodings. Both results are registered toward the ID/EX boundary, and a
// low capture enable holds them while the pipeline is stalled.

package alu_control_pkg;

  // ALU operation select presented to the execute stage
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_SLL   = 3'b010,
    ALU_SRL   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_SLT   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_func_e;

  // Operation class produced by the main control decoder
  typedef enum logic [2:0] {
    OP_RTYPE  = 3'b000,
    OP_MEM    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_ADDI   = 3'b011,
    OP_ANDI   = 3'b100,
    OP_ORI    = 3'b101,
    OP_LI     = 3'b110,
    OP_UNDEF  = 3'b111
  } alu_op_e;

  // Function field of R-type instructions (only the defined codes)
  typedef enum logic [3:0] {
    FN_ADD = 4'b0000,
    FN_SUB = 4'b0001,
    FN_SLL = 4'b0010,
    FN_SRL = 4'b0011,
    FN_AND = 4'b0100,
    FN_OR  = 4'b0101,
    FN_SLT = 4'b0110
  } fun_code_e;

  // One decode result: the ALU select and its undefined-encoding flag
  typedef struct packed {
    alu_func_e func;
    logic      illegal;
  } decode_t;

  // Result used for every undefined encoding and for reset
  localparam decode_t DECODE_ILLEGAL = '{func: ALU_ADD, illegal: 1'b1};
  localparam decode_t DECODE_RESET   = '{func: ALU_ADD, illegal: 1'b0};

endpackage : alu_control_pkg

module alu_control_unit
  import alu_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] aluOp,
  input  logic [3:0] funCode,
  output logic [2:0] aluFunc,
  output logic       illegal_op
);

  decode_t rtype_dec;
  decode_t class_dec;
  decode_t decode_d;
  decode_t decode_q;

  // Decode the R-type function field; codes 0111-1111 are undefined
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    rtype_dec = DECODE_ILLEGAL;
    case (fun_code_e'(funCode))
      FN_ADD:  rtype_dec = '{func: ALU_ADD, illegal: 1'b0};
      FN_SUB:  rtype_dec = '{func: ALU_SUB, illegal: 1'b0};
      FN_SLL:  rtype_dec = '{func: ALU_SLL, illegal: 1'b0};
      FN_SRL:  rtype_dec = '{func: ALU_SRL, illegal: 1'b0};
      FN_AND:  rtype_dec = '{func: ALU_AND, illegal: 1'b0};
      FN_OR:   rtype_dec = '{func: ALU_OR,  illegal: 1'b0};
      FN_SLT:  rtype_dec = '{func: ALU_SLT, illegal: 1'b0};
      default: rtype_dec = DECODE_ILLEGAL;
    endcase
  end

  // Decode the operation class; funCode only matters for the R-type class
  always_comb begin
    class_dec = DECODE_ILLEGAL;
    case (alu_op_e'(aluOp))
      OP_RTYPE:  class_dec = rtype_dec;
      OP_MEM:    class_dec = '{func: ALU_ADD,   illegal: 1'b0};
      OP_BRANCH: class_dec = '{func: ALU_SUB,   illegal: 1'b0};
      OP_ADDI:   class_dec = '{func: ALU_ADD,   illegal: 1'b0};
      OP_ANDI:   class_dec = '{func: ALU_AND,   illegal: 1'b0};
      OP_ORI:    class_dec = '{func: ALU_OR,    illegal: 1'b0};
      OP_LI:     class_dec = '{func: ALU_PASSB, illegal: 1'b0};
      default:   class_dec = DECODE_ILLEGAL;
    endcase
  end

  // Capture a new decode when enabled; otherwise hold for the stall
  always_comb begin
    decode_d = decode_q;
    if (en) begin
      decode_d = class_dec;
    end
  end

  // Output register; synchronous reset takes priority over the enable
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      decode_q <= DECODE_RESET;
    end else begin
      decode_q <= decode_d;
    end
  end

  assign aluFunc    = decode_q.func;
  assign illegal_op = decode_q.illegal;

endmodule : alu_control_unit

// File: tb/tb_alu_control_unit.sv
// Directed testbench for alu_control_unit. Inputs change on the falling
// edge. Outputs are sampled 1 ns after the rising edge that captured them.
// Every expected value is hand-computed from the decode tables.

module tb_alu_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] aluOp;
  logic [3:0] funCode;
  logic [2:0] aluFunc;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  alu_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .aluOp      (aluOp),
    .funCode    (funCode),
    .aluFunc    (aluFunc),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Compare both outputs against hand-computed values
  task automatic check(input string tag, input logic [2:0] exp_func, input logic exp_ill);
    checks++;
    assert (aluFunc === exp_func) else begin
      errors++;
      $error("FAIL %s aluFunc observed=%b expected=%b", tag, aluFunc, exp_func);
    end
    checks++;
    assert (illegal_op === exp_ill) else begin
      errors++;
      $error("FAIL %s illegal_op observed=%b expected=%b", tag, illegal_op, exp_ill);
    end
  endtask

  // Drive one set of inputs, let one rising edge capture them, then check
  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic [3:0] fc, input string tag,
                      input logic [2:0] exp_func, input logic exp_ill);
    @(negedge clk);
    rst     = r;
    en      = e;
    aluOp   = op;
    funCode = fc;
    @(posedge clk);
    #1;
    check(tag, exp_func, exp_ill);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; aluOp = 3'b110; funCode = 4'b0000;

    // Reset held for two edges with a legal PASSB class on the inputs
    step(1'b1, 1'b1, 3'b110, 4'b0000, "reset_1", 3'b000, 1'b0);
    step(1'b1, 1'b1, 3'b110, 4'b0000, "reset_2", 3'b000, 1'b0);
    step(1'b0, 1'b1, 3'b110, 4'b0000, "reset_release", 3'b111, 1'b0);

    // R-type sweep over every defined function code
    step(1'b0, 1'b1, 3'b000, 4'b0000, "rtype_add", 3'b000, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0001, "rtype_sub", 3'b001, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0100, "rtype_and", 3'b100, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0101, "rtype_or",  3'b101, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0010, "rtype_sll", 3'b010, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0011, "rtype_srl", 3'b011, 1'b0);
    step(1'b0, 1'b1, 3'b000, 4'b0110, "rtype_slt", 3'b110, 1'b0);

    // Non-R classes; the function field must be ignored
    step(1'b0, 1'b1, 3'b010, 4'b0101, "class_branch", 3'b001, 1'b0);
    step(1'b0, 1'b1, 3'b011, 4'b0101, "class_addi",   3'b000, 1'b0);
    step(1'b0, 1'b1, 3'b100, 4'b0101, "class_andi",   3'b100, 1'b0);
    step(1'b0, 1'b1, 3'b110, 4'b0101, "class_li",     3'b111, 1'b0);
    step(1'b0, 1'b1, 3'b001, 4'b0101, "class_mem",    3'b000, 1'b0);
    step(1'b0, 1'b1, 3'b101, 4'b0101, "class_ori",    3'b101, 1'b0);
    step(1'b0, 1'b1, 3'b101, 4'b1111, "class_ori_fc_ignored", 3'b101, 1'b0);
    step(1'b0, 1'b1, 3'b100, 4'b0001, "class_andi_fc_ignored", 3'b100, 1'b0);

    // Undefined encodings, then a legal class clears the flag
    step(1'b0, 1'b1, 3'b111, 4'b0000, "illegal_class", 3'b000, 1'b1);
    step(1'b0, 1'b1, 3'b000, 4'b1010, "illegal_funct", 3'b000, 1'b1);
    step(1'b0, 1'b1, 3'b000, 4'b0111, "illegal_funct_0111", 3'b000, 1'b1);
    step(1'b0, 1'b1, 3'b010, 4'b1010, "illegal_cleared", 3'b001, 1'b0);

    // Stall: hold the captured value while the inputs change
    step(1'b0, 1'b1, 3'b100, 4'b0000, "stall_capture", 3'b100, 1'b0);
    step(1'b0, 1'b0, 3'b010, 4'b0000, "stall_hold_1", 3'b100, 1'b0);
    step(1'b0, 1'b0, 3'b010, 4'b0000, "stall_hold_2", 3'b100, 1'b0);
    step(1'b0, 1'b0, 3'b010, 4'b0000, "stall_hold_3", 3'b100, 1'b0);
    step(1'b0, 1'b1, 3'b010, 4'b0000, "stall_release", 3'b001, 1'b0);

    // Stall with an illegal encoding held on the outputs
    step(1'b0, 1'b1, 3'b111, 4'b0000, "stall_ill_capture", 3'b000, 1'b1);
    step(1'b0, 1'b0, 3'b110, 4'b0000, "stall_ill_hold", 3'b000, 1'b1);

    // Reset priority over the enable and over an illegal input
    step(1'b0, 1'b1, 3'b110, 4'b0000, "pre_reset_li", 3'b111, 1'b0);
    step(1'b1, 1'b1, 3'b111, 4'b0000, "reset_priority", 3'b000, 1'b0);
    step(1'b0, 1'b1, 3'b101, 4'b0000, "post_reset_ori", 3'b101, 1'b0);
    step(1'b1, 1'b0, 3'b110, 4'b0000, "reset_while_stalled", 3'b000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_control_unit

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Decode stage ALU controller for the 5-stage pipeline.
- Maps the main-control `aluOp` class and the R-type function field `funCode` to a 3-bit ALU operation select.
- The select is registered, so it is presented to the ID/EX boundary one clock after the inputs.
- Also flags undefined encodings.

Parameters:
- none. All widths are fixed: aluOp 3, funCode 4, aluFunc 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable; 1 = register new decode, 0 = hold outputs (pipeline stall)
- aluOp  input  3  operation class from main control
- funCode  input  4  function field of R-type instructions; ignored unless aluOp = 000
- aluFunc  output  3  registered ALU operation select
- illegal_op  output  1  registered flag: the captured aluOp/funCode combination is undefined

Behaviour:
- ALU select encoding (aluFunc):
  - 000 ADD, 001 SUB, 010 SLL, 011 SRL
  - 100 AND, 101 OR, 110 SLT, 111 PASSB
- aluOp decode:
  - 000 R-type: the result comes from funCode
  - 001 ADD (load/store address)
  - 010 SUB (branch compare)
  - 011 ADD (add-immediate)
  - 100 AND (and-immediate)
  - 101 OR (or-immediate)
  - 110 PASSB (load-immediate)
  - 111 undefined: ADD with illegal_op = 1
- funCode decode (only when aluOp = 000):
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SRL
  - 0100 AND, 0101 OR, 0110 SLT
  - 0111–1111 undefined: ADD with illegal_op = 1
- illegal_op = 0 for every defined combination.
- Decode is purely combinational on aluOp/funCode. The result is captured into the aluFunc/illegal_op registers on the rising clk edge when en = 1.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and are stable until the next capturing edge.
- en = 0: both outputs hold their previous values regardless of input changes.
- Reset:
  - When rst = 1 at a rising edge: aluFunc ← 000 (ADD) and illegal_op ← 0, regardless of en or the inputs.
  - rst has priority over en.
  - Reset mid-operation discards any pending decode; no state beyond the two output registers.
- X/unknown inputs need not be handled specially; no latches, and every case has a default (ADD, illegal).
- funCode changes while aluOp ≠ 000 have no effect on the outputs.

Test Plan:
- Reset: assert rst for 2 cycles with aluOp = 110, en = 1 → aluFunc = 000, illegal_op = 0. Release rst; next edge → aluFunc = 111.
- R-type sweep: aluOp = 000, en = 1. Apply funCode 0000, 0001, 0100, 0101 on successive edges → aluFunc 000, 001, 100, 101 respectively, each one cycle after the input, illegal_op = 0. Also funCode 0010 → 010, 0011 → 011, 0110 → 110.
- Non-R classes: funCode = 0101 held. Apply aluOp 010, 011, 100, 110 → aluFunc 001, 000, 100, 111. Apply aluOp 001 → 000 and 101 → 101. funCode is ignored throughout.
- Illegal encodings:
  - aluOp = 111 → aluFunc = 000, illegal_op = 1.
  - aluOp = 000 with funCode = 1010 → aluFunc = 000, illegal_op = 1.
  - A following legal input (aluOp = 010) clears illegal_op to 0.
- Stall: capture aluOp = 100 (aluFunc = 100), then drop en and change aluOp to 010 for 3 cycles → aluFunc stays 100. Raise en → aluFunc = 001 after the next edge.
- Reset priority: en = 1, aluOp = 111, rst = 1 on the same edge → aluFunc = 000, illegal_op = 0.
